// File: rtl/seq_mult_pkg.sv
// Shared definitions for the shift-add sequential multiplier controller:
// FSM state encoding and the iteration-counter width helper.
package seq_mult_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CALC  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Width of an iteration counter that must hold 0..n-1.
  function automatic int cw_of(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Host/datapath handshake bundle of the sequential multiplier controller.
// The master side is the host plus datapath; the slave side is the controller.
interface seq_mult_ctrl_if #(
  parameter int CW = 4
);
  logic          start;
  logic          ack;
  logic          q0;
  logic          ld_en;
  logic          acc_clr;
  logic          add_en;
  logic          shift_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_cnt;

  modport master (
    output start, ack, q0,
    input  ld_en, acc_clr, add_en, shift_en, busy, done, bit_cnt
  );

  modport slave (
    input  start, ack, q0,
    output ld_en, acc_clr, add_en, shift_en, busy, done, bit_cnt
  );
endinterface

// File: rtl/mult_bit_counter.sv
// Iteration counter for the sequential multiplier: counts 0..n-1 and flags
// the last iteration. A clear request always wins over an increment.
module mult_bit_counter
  import seq_mult_pkg::*;
#(
  parameter int n  = 10,
  parameter int CW = cw_of(n)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          term
);

  // Count register: reset and clear both return to zero, clear beats inc.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + CW'(1);
  end

  assign term = (count == CW'(n - 1));

endmodule

// File: rtl/seq_mult_ctrl.sv
// Controller for the shift-add sequential multiplier. Sequences operand load,
// accumulator clear, n add/shift iterations and the start/done/ack handshake.
// Holds no operand data: only the state register and the iteration counter.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int  n  = 10,
  localparam int CW = cw_of(n)
) (
  input  logic           clk,
  input  logic           rst,
  seq_mult_ctrl_if.slave bus
);

  state_t        state, state_nxt;
  logic          cnt_clr, cnt_inc, cnt_term;
  logic [CW-1:0] cnt;
  logic          ld_en, acc_clr, add_en, shift_en, busy, done;

  mult_bit_counter #(.n(n), .CW(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt),
    .term  (cnt_term)
  );

  // State register; reset lands in IDLE so every decoded output is 0.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and output decode; add_en is the only output that looks at q0.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    ld_en     = 1'b0;
    acc_clr   = 1'b0;
    add_en    = 1'b0;
    shift_en  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_LOAD;
          cnt_clr   = 1'b1;
        end
      end
      ST_LOAD: begin
        ld_en     = 1'b1;
        acc_clr   = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_CALC;
      end
      ST_CALC: begin
        busy      = 1'b1;
        add_en    = bus.q0;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
        if (cnt_term) begin
          state_nxt = ST_DONE;
          cnt_clr   = 1'b1;
        end else begin
          state_nxt = ST_CALC;
          cnt_inc   = 1'b1;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (bus.ack) begin
          if (bus.start) begin
            // Back-to-back operation: skip the IDLE cycle.
            state_nxt = ST_LOAD;
            cnt_clr   = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.ld_en    = ld_en;
  assign bus.acc_clr  = acc_clr;
  assign bus.add_en   = add_en;
  assign bus.shift_en = shift_en;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.bit_cnt  = cnt;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl. Two instances (n=4 and n=10) are
// compared every cycle against a step-index model of one operation, and
// directed scenarios pin latency, strobe counts and handshake behaviour.
module tb_seq_mult_ctrl;
  import seq_mult_pkg::*;

  localparam int NN [2] = '{4, 10};

  typedef struct packed {
    logic       ld;
    logic       acc;
    logic       add;
    logic       shf;
    logic       busy;
    logic       done;
    logic [3:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst4, rst10;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_mult_ctrl_if #(.CW(cw_of(4)))  bus4 ();
  seq_mult_ctrl_if #(.CW(cw_of(10))) bus10 ();

  seq_mult_ctrl #(.n(4))  u4  (.clk(clk), .rst(rst4),  .bus(bus4));
  seq_mult_ctrl #(.n(10)) u10 (.clk(clk), .rst(rst10), .bus(bus10));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- stimulus / observation helpers ----------------
  task automatic set_in(input int which, input logic st, input logic ak, input logic q);
    if (which == 0) begin
      bus4.start = st; bus4.ack = ak; bus4.q0 = q;
    end else begin
      bus10.start = st; bus10.ack = ak; bus10.q0 = q;
    end
  endtask

  function automatic obs_t get_out(input int which);
    obs_t o = '0;
    if (which == 0) begin
      o.ld = bus4.ld_en; o.acc = bus4.acc_clr; o.add = bus4.add_en; o.shf = bus4.shift_en;
      o.busy = bus4.busy; o.done = bus4.done; o.cnt = 4'(bus4.bit_cnt);
    end else begin
      o.ld = bus10.ld_en; o.acc = bus10.acc_clr; o.add = bus10.add_en; o.shf = bus10.shift_en;
      o.busy = bus10.busy; o.done = bus10.done; o.cnt = 4'(bus10.bit_cnt);
    end
    return o;
  endfunction

  // ---------------- behavioural model ----------------
  // Position within an operation: -1 idle, 0 load, 1..2n alternate
  // calc (odd) / shift (even), 2n+1 result held waiting for ack.
  int step [2] = '{-1, -1};

  function automatic int model_next(input int s, input int n, input logic r,
                                    input logic st, input logic ak);
    if (r)               return -1;
    if (s < 0)           return st ? 0 : -1;
    if (s <= 2 * n)      return s + 1;
    if (ak)              return st ? 0 : -1;
    return s;
  endfunction

  function automatic obs_t model_obs(input int s, input int n, input logic q);
    obs_t e = '0;
    bit   iter = (s >= 1) && (s <= 2 * n);
    e.ld   = (s == 0);
    e.acc  = (s == 0);
    e.busy = (s >= 0) && (s <= 2 * n);
    e.add  = iter && (s % 2 == 1) && q;
    e.shf  = iter && (s % 2 == 0);
    e.done = (s == 2 * n + 1);
    e.cnt  = iter ? 4'((s - 1) / 2) : 4'd0;
    return e;
  endfunction

  always @(posedge clk) begin
    step[0] <= model_next(step[0], NN[0], rst4,  bus4.start,  bus4.ack);
    step[1] <= model_next(step[1], NN[1], rst10, bus10.start, bus10.ack);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_dut4",  get_out(0), model_obs(step[0], NN[0], bus4.q0));
      check("cycle_dut10", get_out(1), model_obs(step[1], NN[1], bus10.q0));
    end
  end

  // ---------------- operation runner ----------------
  int          r_ld_cnt, r_ld_cyc, r_add_cnt, r_shf_cnt, r_busy_cnt, r_done_cyc;
  logic [9:0]  r_add_mask;

  // Starts one operation (with ack=1 too when chaining out of DONE) and
  // follows it cycle by cycle until done or a cycle budget expires.
  // Cycle c is the cycle after edge E+c, E being the edge that samples start.
  task automatic run_op(input int which, input logic [9:0] pat, input bit noise,
                        input bit with_ack);
    int   n = NN[which];
    obs_t o;
    r_ld_cnt = 0; r_ld_cyc = -1; r_add_cnt = 0; r_shf_cnt = 0;
    r_busy_cnt = 0; r_done_cyc = -1; r_add_mask = '0;
    @(posedge clk); #1;
    set_in(which, 1'b1, with_ack, 1'($urandom));
    @(posedge clk); #1;
    for (int c = 0; c <= 2 * n + 4 && r_done_cyc < 0; c++) begin
      logic q, st, ak;
      q  = (c % 2 == 1 && c < 2 * n) ? pat[(c - 1) / 2] : 1'($urandom);
      st = (noise && c <= 2 * n) ? 1'($urandom) : 1'b0;
      ak = (noise && c <= 2 * n) ? 1'($urandom) : 1'b0;
      set_in(which, st, ak, q);
      @(negedge clk);
      o = get_out(which);
      if (o.ld)   begin r_ld_cnt++; r_ld_cyc = c; end
      if (o.add)  begin
        r_add_cnt++;
        if (c % 2 == 1 && c < 2 * n) r_add_mask[(c - 1) / 2] = 1'b1;
      end
      if (o.shf)  r_shf_cnt++;
      if (o.busy) r_busy_cnt++;
      if (o.done) r_done_cyc = c;
      else begin
        @(posedge clk); #1;
      end
    end
    set_in(which, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ack_out(input int which);
    @(posedge clk); #1;
    set_in(which, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(which, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_run(input string tag, input int n, input logic [9:0] pat);
    logic [9:0] mask = pat & 10'((1 << n) - 1);
    check({tag, "_ld_cnt"},   r_ld_cnt,   1);
    check({tag, "_ld_cyc"},   r_ld_cyc,   0);
    check({tag, "_shf_cnt"},  r_shf_cnt,  n);
    check({tag, "_busy_cnt"}, r_busy_cnt, 2 * n + 1);
    check({tag, "_done_cyc"}, r_done_cyc, 2 * n + 1);
    check({tag, "_add_cnt"},  r_add_cnt,  $countones(mask));
    check({tag, "_add_mask"}, r_add_mask, mask);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    obs_t       hold_exp;
    obs_t       o;
    logic [9:0] pat;
    bit         chain;

    rst4 = 1'b1; rst10 = 1'b1;
    set_in(0, 1'b1, 1'b0, 1'b0);
    set_in(1, 1'b0, 1'b0, 1'b0);

    // Reset held two cycles with start=1: outputs all zero.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_outs", get_out(0), 32'd0);
    end
    @(posedge clk); #1;
    rst4 = 1'b0; rst10 = 1'b0;
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    o = get_out(0);
    check("first_start_ld", o.ld, 1'b1);
    check("first_start_cnt", o.cnt, 4'd0);
    for (int c = 0; c < 40 && !get_out(0).done; c++) @(negedge clk);
    check("first_start_done", get_out(0).done, 1'b1);
    ack_out(0);

    // Basic run: q0 = 1,0,1,1 on bits 0..3 gives add_en on bits 0, 2, 3.
    run_op(0, 10'b1101, 1'b0, 1'b0);
    check_run("basic", 4, 10'b1101);
    check("basic_add_lit", r_add_mask, 10'b1101);
    check("basic_done_lit", r_done_cyc, 9);
    check("basic_busy_lit", r_busy_cnt, 9);

    // Handshake hold: done stays high with no strobes while ack=0.
    hold_exp = '0;
    hold_exp.done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_done", get_out(0), hold_exp);
    end
    ack_out(0);
    @(negedge clk);
    check("after_ack_idle", get_out(0), 32'd0);

    // Back-to-back: ack and start together in DONE go straight to LOAD.
    run_op(0, 10'($urandom), 1'b0, 1'b0);
    check("pre_b2b_done", r_done_cyc, 9);
    pat = 10'b0110;
    run_op(0, pat, 1'b0, 1'b1);
    check_run("b2b", 4, pat);
    ack_out(0);

    // Ignored inputs: random start/ack while busy change nothing.
    pat = 10'b1011;
    run_op(0, pat, 1'b1, 1'b0);
    check_run("ignored", 4, pat);
    ack_out(0);

    // Randomised operations, optionally chained back-to-back.
    chain = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pat = 10'($urandom);
      run_op(0, pat, 1'($urandom), chain);
      check_run("rand4", 4, pat);
      chain = 1'($urandom);
      if (!chain) ack_out(0);
    end
    if (chain) ack_out(0);

    // Mid-operation reset on the n=10 instance at bit_cnt=5 in SHIFT.
    @(posedge clk); #1;
    set_in(1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_in(1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    @(negedge clk);
    o = get_out(1);
    check("midrst_pre_shf", o.shf, 1'b1);
    check("midrst_pre_cnt", o.cnt, 4'd5);
    rst10 = 1'b1;
    @(posedge clk); #1;
    rst10 = 1'b0;
    @(negedge clk);
    check("midrst_idle", get_out(1), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_idle2", get_out(1), 32'd0);

    pat = 10'($urandom);
    run_op(1, pat, 1'b0, 1'b0);
    check_run("fresh10", 10, pat);
    check("fresh10_done_lit", r_done_cyc, 21);
    ack_out(1);

    pat = 10'($urandom);
    run_op(1, pat, 1'b1, 1'b0);
    check_run("rand10", 10, pat);
    ack_out(1);

    @(posedge clk); #1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
